// File: rtl/tlb_req_arbiter.sv
// Round-robin arbiter sharing one TLB between NUM_REQ requesters, one translation in flight.
// Optional stuck-translation abort is compiled in with `define TLB_ARB_TIMEOUT_EN.
module tlb_req_arbiter #(
   parameter int NUM_REQ        = 2,
   parameter int TIMEOUT_CYCLES = 256,
   localparam int IDW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_REQ-1:0]     req_valid_i,
   output logic [NUM_REQ-1:0]     req_ready_o,
   input  logic [32*NUM_REQ-1:0]  req_vaddr_i,
   input  logic [3*NUM_REQ-1:0]   req_access_type_i,
   output logic [NUM_REQ-1:0]     resp_valid_o,
   output logic [31:0]            resp_paddr_o,
   output logic                   resp_hit_o,
   output logic                   resp_fault_o,
   output logic                   resp_timeout_o,
   output logic                   tlb_req_valid_o,
   output logic [31:0]            tlb_vaddr_o,
   output logic [2:0]             tlb_access_type_o,
   input  logic                   tlb_resp_valid_i,
   input  logic [31:0]            tlb_paddr_i,
   input  logic                   tlb_hit_i,
   input  logic                   tlb_fault_i,
   output logic                   busy_o,
   output logic [IDW-1:0]         grant_id_o,
   output logic [1:0]             dbg_state_o
);

   localparam int CW = IDW + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t               state;
   logic [IDW-1:0]       ptr;
   logic [IDW-1:0]       win_id;
   logic                 win_found;
   logic [CW-1:0]        cand;
   logic [NUM_REQ-1:0]   win_onehot;
   logic [NUM_REQ-1:0]   owner_onehot;
   logic [IDW-1:0]       ptr_next;
   logic [31:0]          sel_vaddr;
   logic [2:0]           sel_type;

`ifdef TLB_ARB_TIMEOUT_EN
   localparam int TCW = $clog2(TIMEOUT_CYCLES);
   logic [TCW-1:0]       wait_cnt;
   logic                 timeout_q;
`endif

   if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_cfg_check
      $error("tlb_req_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 2");
   end

   // Round-robin search starting at ptr; the sum of two ids wraps at most once.
   always_comb begin
      win_id    = '0;
      win_found = 1'b0;
      cand      = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = {1'b0, ptr} + CW'(i);
         if (cand >= CW'(NUM_REQ))
            cand = cand - CW'(NUM_REQ);
         if (!win_found && req_valid_i[cand[IDW-1:0]]) begin
            win_found = 1'b1;
            win_id    = cand[IDW-1:0];
         end
      end
   end

   always_comb begin
      sel_vaddr = '0;
      sel_type  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (win_id == IDW'(k)) begin
            sel_vaddr = req_vaddr_i[32*k +: 32];
            sel_type  = req_access_type_i[3*k +: 3];
         end
      end
   end

   always_comb begin
      win_onehot           = '0;
      win_onehot[win_id]   = 1'b1;
      owner_onehot         = '0;
      owner_onehot[grant_id_o] = 1'b1;
   end

   assign ptr_next = (win_id == IDW'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;

   // Valid/ready: requester k transfers on a rising edge where req_valid_i[k] & req_ready_o[k];
   // ready is offered only in IDLE, only to the round-robin winner, and data need only be stable then.
   assign req_ready_o = (state == S_IDLE && !rst && win_found) ? win_onehot : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state             <= S_IDLE;
         ptr               <= '0;
         grant_id_o        <= '0;
         tlb_req_valid_o   <= 1'b0;
         tlb_vaddr_o       <= '0;
         tlb_access_type_o <= '0;
         resp_valid_o      <= '0;
         resp_paddr_o      <= '0;
         resp_hit_o        <= 1'b0;
         resp_fault_o      <= 1'b0;
`ifdef TLB_ARB_TIMEOUT_EN
         wait_cnt          <= '0;
         timeout_q         <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (win_found) begin
                  tlb_vaddr_o       <= sel_vaddr;
                  tlb_access_type_o <= sel_type;
                  grant_id_o        <= win_id;
                  ptr               <= ptr_next;
                  tlb_req_valid_o   <= 1'b1;
                  state             <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               tlb_req_valid_o <= 1'b0;
`ifdef TLB_ARB_TIMEOUT_EN
               wait_cnt        <= '0;
`endif
               state           <= S_WAIT;
            end
            S_WAIT: begin
               // A real response wins over a timeout expiring in the same cycle.
               if (tlb_resp_valid_i) begin
                  resp_paddr_o <= tlb_paddr_i;
                  resp_hit_o   <= tlb_hit_i;
                  resp_fault_o <= tlb_fault_i;
`ifdef TLB_ARB_TIMEOUT_EN
                  timeout_q    <= 1'b0;
`endif
                  resp_valid_o <= owner_onehot;
                  state        <= S_RESP;
               end
`ifdef TLB_ARB_TIMEOUT_EN
               else if (wait_cnt == TCW'(TIMEOUT_CYCLES - 1)) begin
                  resp_paddr_o <= '0;
                  resp_hit_o   <= 1'b0;
                  resp_fault_o <= 1'b1;
                  timeout_q    <= 1'b1;
                  resp_valid_o <= owner_onehot;
                  state        <= S_RESP;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
`endif
            end
            S_RESP: begin
               resp_valid_o <= '0;
               state        <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef TLB_ARB_TIMEOUT_EN
   assign resp_timeout_o = timeout_q;
`else
   assign resp_timeout_o = 1'b0;
`endif

   assign busy_o      = (state != S_IDLE);
   assign dbg_state_o = state;

endmodule

// File: tb/tb_tlb_req_arbiter.sv
// Bench for tlb_req_arbiter: vector table for full transactions, hand sequences for reset and timeout.
// Timeout sequences run only when TLB_ARB_TIMEOUT_EN is defined (DUT built with TIMEOUT_CYCLES 8).
module tb_tlb_req_arbiter;

   localparam int NUM_REQ = 2;
   localparam int TO      = 8;
   localparam int IDW     = 1;
   localparam int W       = NUM_REQ + 32 + 3;
   localparam int NVEC    = 11;

   logic                  clk;
   logic                  rst;
   logic [NUM_REQ-1:0]    req_valid_i;
   logic [NUM_REQ-1:0]    req_ready_o;
   logic [32*NUM_REQ-1:0] req_vaddr_i;
   logic [3*NUM_REQ-1:0]  req_access_type_i;
   logic [NUM_REQ-1:0]    resp_valid_o;
   logic [31:0]           resp_paddr_o;
   logic                  resp_hit_o;
   logic                  resp_fault_o;
   logic                  resp_timeout_o;
   logic                  tlb_req_valid_o;
   logic [31:0]           tlb_vaddr_o;
   logic [2:0]            tlb_access_type_o;
   logic                  tlb_resp_valid_i;
   logic [31:0]           tlb_paddr_i;
   logic                  tlb_hit_i;
   logic                  tlb_fault_i;
   logic                  busy_o;
   logic [IDW-1:0]        grant_id_o;
   logic [1:0]            dbg_state_o;

   tlb_req_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYCLES(TO)) dut (
      .clk               (clk),
      .rst               (rst),
      .req_valid_i       (req_valid_i),
      .req_ready_o       (req_ready_o),
      .req_vaddr_i       (req_vaddr_i),
      .req_access_type_i (req_access_type_i),
      .resp_valid_o      (resp_valid_o),
      .resp_paddr_o      (resp_paddr_o),
      .resp_hit_o        (resp_hit_o),
      .resp_fault_o      (resp_fault_o),
      .resp_timeout_o    (resp_timeout_o),
      .tlb_req_valid_o   (tlb_req_valid_o),
      .tlb_vaddr_o       (tlb_vaddr_o),
      .tlb_access_type_o (tlb_access_type_o),
      .tlb_resp_valid_i  (tlb_resp_valid_i),
      .tlb_paddr_i       (tlb_paddr_i),
      .tlb_hit_i         (tlb_hit_i),
      .tlb_fault_i       (tlb_fault_i),
      .busy_o            (busy_o),
      .grant_id_o        (grant_id_o),
      .dbg_state_o       (dbg_state_o)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard ----------------
   int n_cmp  = 0;
   int n_fail = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] mon_e;

   typedef struct {
      logic [1:0]  valid;
      logic [31:0] va0;
      logic [31:0] va1;
      logic [2:0]  t0;
      logic [2:0]  t1;
      logic [31:0] pa;
      logic        hit;
      logic        fault;
      int          exp_id;
   } vec_t;

   vec_t vecs[NVEC];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_a"}, 64'({req_ready_o, resp_valid_o, resp_paddr_o, resp_hit_o,
                               resp_fault_o, resp_timeout_o}), 64'd0);
      check({name, "_b"}, 64'({tlb_req_valid_o, tlb_vaddr_o, tlb_access_type_o,
                               busy_o, grant_id_o}), 64'd0);
   endtask

   // Response monitor: every resp_valid_o pulse must match the oldest expected response.
   always @(negedge clk) begin
      if (busy_o)
         check("ready_outside_idle", 64'(req_ready_o), 64'd0);
      if (resp_valid_o !== '0) begin
         if (exp_q.size() == 0) begin
            check("unexpected_resp", 64'(resp_valid_o), 64'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("resp", 64'({resp_valid_o, resp_paddr_o, resp_hit_o, resp_fault_o,
                               resp_timeout_o}), 64'(mon_e));
         end
      end
   end

   // ---------------- driver ----------------
   // Entered at a negedge with the DUT in IDLE; returns at the negedge after RESP.
   task automatic run_txn(input vec_t v);
      logic [1:0]  oh;
      logic [31:0] ev;
      logic [2:0]  et;
      oh = 2'b01 << v.exp_id;
      ev = (v.exp_id == 1) ? v.va1 : v.va0;
      et = (v.exp_id == 1) ? v.t1 : v.t0;
      req_valid_i       = v.valid;
      req_vaddr_i       = {v.va1, v.va0};
      req_access_type_i = {v.t1, v.t0};
      #1;
      check("ready_onehot", 64'(req_ready_o), 64'(oh));
      check("idle_not_busy", 64'(busy_o), 64'd0);
      exp_q.push_back({oh, v.pa, v.hit, v.fault, 1'b0});
      @(negedge clk);
      req_vaddr_i       = {$urandom, $urandom};
      req_access_type_i = 6'($urandom_range(0, 63));
      check("issue_pulse", 64'(tlb_req_valid_o), 64'd1);
      check("tlb_vaddr", 64'(tlb_vaddr_o), 64'(ev));
      check("tlb_type", 64'(tlb_access_type_o), 64'(et));
      check("grant_id", 64'(grant_id_o), 64'(v.exp_id));
      check("busy_issue", 64'(busy_o), 64'd1);
      @(negedge clk);
      check("pulse_len_wait", 64'(tlb_req_valid_o), 64'd0);
      check("state_wait", 64'(dbg_state_o), 64'd2);
      check("vaddr_held", 64'(tlb_vaddr_o), 64'(ev));
      @(negedge clk);
      tlb_resp_valid_i = 1'b1;
      tlb_paddr_i      = v.pa;
      tlb_hit_i        = v.hit;
      tlb_fault_i      = v.fault;
      @(negedge clk);
      tlb_resp_valid_i = 1'b0;
      tlb_paddr_i      = 32'hDEAD_BEEF;
      tlb_hit_i        = ~v.hit;
      tlb_fault_i      = ~v.fault;
      check("resp_strobe", 64'(resp_valid_o), 64'(oh));
      check("pulse_len_resp", 64'(tlb_req_valid_o), 64'd0);
      @(negedge clk);
      check("resp_one_cycle", 64'(resp_valid_o), 64'd0);
   endtask

   // ---------------- test ----------------
   initial begin
      rst               = 1'b1;
      req_valid_i       = '0;
      req_vaddr_i       = '0;
      req_access_type_i = '0;
      tlb_resp_valid_i  = 1'b0;
      tlb_paddr_i       = '0;
      tlb_hit_i         = 1'b0;
      tlb_fault_i       = 1'b0;

      // Vector table: single request, 6-way fairness with a page fault, then mixed masks.
      for (int i = 0; i < NVEC; i++) begin
         vecs[i].valid  = 2'b11;
         vecs[i].va0    = $urandom;
         vecs[i].va1    = $urandom;
         vecs[i].t0     = 3'($urandom_range(0, 2));
         vecs[i].t1     = 3'($urandom_range(0, 2));
         vecs[i].pa     = $urandom;
         vecs[i].hit    = 1'b1;
         vecs[i].fault  = 1'b0;
         vecs[i].exp_id = (i + 1) % 2;
      end
      vecs[0] = '{2'b10, 32'h0, 32'h0001_2345, 3'b000, 3'b001, 32'h000A_B345, 1'b1, 1'b0, 1};
      vecs[3].pa    = 32'h0;
      vecs[3].hit   = 1'b0;
      vecs[3].fault = 1'b1;
      vecs[7].valid = 2'b01;  vecs[7].exp_id  = 0;
      vecs[8].valid = 2'b10;  vecs[8].exp_id  = 1;
      vecs[9].valid = 2'b11;  vecs[9].exp_id  = 0;
      vecs[10].valid = 2'b11; vecs[10].exp_id = 1;

      repeat (3) @(negedge clk);
      check_all_zero("reset_held");
      rst = 1'b0;
      @(negedge clk);
      check_all_zero("reset_released");

      for (int i = 0; i < NVEC; i++) begin
         if (i == 10) begin
            // Idle cycles must not rotate priority: requester 1 is still next.
            req_valid_i = '0;
            repeat (3) @(negedge clk);
            check("idle_no_ready", 64'(req_ready_o), 64'd0);
         end
         run_txn(vecs[i]);
      end

      // Reset during WAIT discards the transaction; a stale TLB response is ignored.
      req_valid_i = 2'b01;
      req_vaddr_i = {$urandom, $urandom};
      #1;
      check("abort_ready", 64'(req_ready_o), 64'd1);
      @(negedge clk);
      req_valid_i = '0;
      check("abort_issue", 64'(tlb_req_valid_o), 64'd1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_all_zero("reset_mid_wait");
      tlb_resp_valid_i = 1'b1;
      tlb_paddr_i      = 32'h1234_5678;
      rst              = 1'b0;
      @(negedge clk);
      tlb_resp_valid_i = 1'b0;
      check_all_zero("stale_resp_ignored");
      run_txn('{2'b11, 32'h0000_4000, 32'h0000_5000, 3'b010, 3'b000, 32'h0008_8000, 1'b1, 1'b0, 0});

`ifdef TLB_ARB_TIMEOUT_EN
      // TLB never answers: timeout fault after TO WAIT cycles; a late response is dropped.
      req_valid_i = 2'b01;
      req_vaddr_i = {32'h0, 32'h0000_7000};
      exp_q.push_back({2'b01, 32'h0, 1'b0, 1'b1, 1'b1});
      @(negedge clk);
      req_valid_i = '0;
      repeat (TO) @(negedge clk);
      check("timeout_not_early", 64'(resp_valid_o), 64'd0);
      @(negedge clk);
      check("timeout_strobe", 64'({resp_valid_o, resp_timeout_o}), 64'({2'b01, 1'b1}));
      repeat (3) @(negedge clk);
      tlb_resp_valid_i = 1'b1;
      tlb_paddr_i      = 32'hCAFE_0000;
      @(negedge clk);
      tlb_resp_valid_i = 1'b0;
      repeat (2) @(negedge clk);
      check("late_resp_ignored", 64'({resp_valid_o, busy_o}), 64'd0);

      // Response on exactly the last WAIT cycle beats the timeout.
      req_valid_i = 2'b10;
      req_vaddr_i = {32'h0000_9000, 32'h0};
      exp_q.push_back({2'b10, 32'h0003_3000, 1'b1, 1'b0, 1'b0});
      @(negedge clk);
      req_valid_i = '0;
      repeat (TO) @(negedge clk);
      tlb_resp_valid_i = 1'b1;
      tlb_paddr_i      = 32'h0003_3000;
      tlb_hit_i        = 1'b1;
      tlb_fault_i      = 1'b0;
      @(negedge clk);
      tlb_resp_valid_i = 1'b0;
      check("edge_resp_strobe", 64'({resp_valid_o, resp_timeout_o}), 64'({2'b10, 1'b0}));
      repeat (2) @(negedge clk);
`endif

      @(negedge clk);
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/tlb_req_arbiter.md
# tlb_req_arbiter

Shares one translation TLB between NUM_REQ requesters (e.g. fetch unit, load/store unit, prefetcher) with round-robin arbitration and one outstanding translation at a time. Sits between the requester ports and the TLB processor interface. Accepts a request, issues it to the TLB as a one-cycle pulse, waits for the TLB response and routes it back to the granted requester. Optionally aborts stuck translations with a timeout fault.

## Interface
- NUM_REQ, 2, number of requesters (2..8)
- TIMEOUT_CYCLES, 256, WAIT-state cycles before timeout abort (used only with timeout compiled in); ≥2
- IDW, $clog2(NUM_REQ) (min 1), grant id width (localparam)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid_i  in  NUM_REQ  per-requester request valid
- req_ready_o  out  NUM_REQ  per-requester accept; request transfers when valid & ready
- req_vaddr_i  in  32*NUM_REQ  virtual address, requester k at [32k+31:32k]
- req_access_type_i  in  3*NUM_REQ  000 fetch, 001 read, 010 write; requester k at [3k+2:3k]
- resp_valid_o  out  NUM_REQ  one-cycle response strobe to the owning requester
- resp_paddr_o  out  32  physical address (shared, qualified by resp_valid_o)
- resp_hit_o  out  1  TLB hit flag
- resp_fault_o  out  1  access/page fault or timeout
- resp_timeout_o  out  1  response was produced by timeout abort
- tlb_req_valid_o  out  1  request pulse to TLB
- tlb_vaddr_o  out  32  held from ISSUE through WAIT
- tlb_access_type_o  out  3  held from ISSUE through WAIT
- tlb_resp_valid_i  in  1  TLB response valid
- tlb_paddr_i  in  32  TLB physical address
- tlb_hit_i  in  1  TLB hit
- tlb_fault_i  in  1  TLB fault
- busy_o  out  1  high in any state other than IDLE
- grant_id_o  out  IDW  index of current/last granted requester

## Operation
- FSM: IDLE → ISSUE → WAIT → RESP → IDLE.
- IDLE: combinationally select the winner among asserted req_valid_i, round-robin starting at ptr. req_ready_o is one-hot on the winner, zero when none is valid. On transfer, latch vaddr, access type and id. Set ptr = (id+1) mod NUM_REQ. Go to ISSUE.
- req_ready_o is zero in every state except IDLE.
- ISSUE: tlb_req_valid_o = 1 for exactly this cycle. Go to WAIT.
- WAIT: on tlb_resp_valid_i, latch paddr/hit/fault and clear timeout flag. Go to RESP.
- RESP: resp_valid_o[id] = 1 for one cycle; response data driven from the latch. Go to IDLE.
- tlb_resp_valid_i outside WAIT is ignored (stale/late response).
- Requester data must stay stable only in the transfer cycle; the arbiter owns the copy afterwards.
- Reset: state IDLE, ptr 0, all outputs 0 (req_ready_o, resp_valid_o, resp_paddr_o, resp_hit_o, resp_fault_o, resp_timeout_o, tlb_req_valid_o, tlb_vaddr_o, tlb_access_type_o, busy_o, grant_id_o). rst mid-transaction discards it; no response is produced.

## Timing
- Accept (cycle 0) → tlb_req_valid_o at cycle 1.
- TLB response at cycle n → resp_valid_o at cycle n+1.
- Next accept is possible the cycle after RESP.
- Minimum turnaround: 4 cycles per request for the arbiter alone. With the TLB's current 2-cycle hit path (IDLE→LOOKUP), a hit takes accept→resp_valid = 4 cycles.
- ptr advances only on transfer; idle cycles do not rotate priority.
- Fairness: with all requesters continuously valid, each is served once per NUM_REQ grants.

## Configuration
- TLB_ARB_TIMEOUT_EN defined:
  - A wait counter clears on entering WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without a response, go to RESP with paddr 0, hit 0, fault 1, timeout 1.
  - A response arriving in the same cycle the count is reached takes precedence (normal response, timeout 0).
- TLB_ARB_TIMEOUT_EN undefined: no counter; WAIT waits indefinitely; resp_timeout_o is tied 0.

## Test plan
- Single request, requester 1, vaddr 0x0001_2345, type 001; TLB answers 2 cycles after pulse with paddr 0x000A_B345, hit 1 → exactly one tlb_req_valid_o pulse with matching vaddr/type, then resp_valid_o = 2'b10 with paddr 0x000A_B345, hit 1, fault 0.
- Both requesters valid continuously, 6 requests → grant order 0,1,0,1,0,1; req_ready_o never asserted outside IDLE; grant_id_o tracks it.
- TLB returns fault 1, hit 0 (PTW page fault) → owning requester gets resp_fault_o 1, hit 0; next request proceeds normally.
- TLB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES 8, TLB never responds → resp_valid_o with fault 1, timeout 1 after 8 WAIT cycles. A TLB response injected 3 cycles later is ignored (no resp_valid_o).
- TLB_ARB_TIMEOUT_EN, response on exactly the 8th WAIT cycle → normal response, timeout 0.
- Assert rst during WAIT, then release → all outputs 0; no resp_valid_o; next grant goes to requester 0.
